// File: rtl/layer_collector.sv
// ---------------------------------------------------------------------------
// layer_collector
//
// Collects the per-neuron completion pulses and results of one neuron layer.
// Each result is buffered the first time its lane reports in. Once every
// lane has reported, the complete vector is handed to the next layer with a
// one-cycle start pulse, as soon as that layer reports it is ready.
//
// Parameters
//   N          neurons in the producing layer / input lanes of the consumer
//   W          width of one neuron result
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   end_in     per-lane completion pulses; bit i qualifies lane i of out_in
//   out_in     packed producer results, lane i at [i*W +: W]
//   next_ready consumer layer idle; a fire only happens while this is high
//   layer_out  registered packed vector for the consumer, changes on fires
//   start_out  one-cycle start pulse to the consumer
//   busy       a round is partly collected or a full vector is waiting
//   dup_err    sticky: a lane reported twice within one round
//   ovr_err    sticky: a lane reported while a full vector was waiting
//   fire_cnt   number of fires since reset, wraps at 16 bits
// ---------------------------------------------------------------------------
module layer_collector #(
    parameter int N = 9,
    parameter int W = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   end_in,
    input  logic [N*W-1:0] out_in,
    input  logic           next_ready,
    output logic [N*W-1:0] layer_out,
    output logic           start_out,
    output logic           busy,
    output logic           dup_err,
    output logic           ovr_err,
    output logic [15:0]    fire_cnt
);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    localparam logic [N-1:0] ALL_LANES = '1;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   mask;
    logic [N-1:0]   mask_next;
    logic [N-1:0]   accept;
    logic [N*W-1:0] shadow;
    logic [N*W-1:0] shadow_next;
    logic           fire;
    logic           dup_hit;
    logic           ovr_hit;

    // Next-state and round bookkeeping. In COLLECT only lanes that have not
    // yet reported are accepted; repeats are flagged and their data dropped.
    // On a fire edge the round restarts with an empty mask, so any lanes
    // reporting on that same edge already belong to the new round. While a
    // full vector waits without a fire, arrivals are dropped and flagged.
    always_comb begin
        state_next  = state;
        mask_next   = mask;
        shadow_next = shadow;
        accept      = '0;
        fire        = 1'b0;
        dup_hit     = 1'b0;
        ovr_hit     = 1'b0;

        case (state)
            COLLECT: begin
                accept    = end_in & ~mask;
                dup_hit   = |(end_in & mask);
                mask_next = mask | accept;
            end
            HOLD: begin
                if (next_ready) begin
                    fire      = 1'b1;
                    accept    = end_in;
                    mask_next = end_in;
                end else begin
                    ovr_hit = |end_in;
                end
            end
            default: ;
        endcase

        for (int i = 0; i < N; i++) begin
            if (accept[i]) begin
                shadow_next[i*W +: W] = out_in[i*W +: W];
            end
        end

        // A round that completes (including one completed entirely on the
        // fire edge) goes straight to HOLD; a waiting vector stays in HOLD.
        if (state == COLLECT || fire) begin
            state_next = (mask_next == ALL_LANES) ? HOLD : COLLECT;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Collection buffer and registered outputs. layer_out captures the shadow
    // as it stood before this edge, so new-round data written on a fire edge
    // never leaks into the vector being handed over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask      <= '0;
            shadow    <= '0;
            layer_out <= '0;
            start_out <= 1'b0;
            busy      <= 1'b0;
            dup_err   <= 1'b0;
            ovr_err   <= 1'b0;
            fire_cnt  <= '0;
        end else begin
            mask      <= mask_next;
            shadow    <= shadow_next;
            start_out <= fire;
            busy      <= (|mask_next) || (state_next == HOLD);
            if (fire) begin
                layer_out <= shadow;
                fire_cnt  <= fire_cnt + 16'd1;
            end
            if (dup_hit) begin
                dup_err <= 1'b1;
            end
            if (ovr_hit) begin
                ovr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_collector.sv
// ---------------------------------------------------------------------------
// tb_layer_collector
//
// Directed testbench for layer_collector with the default 9 lanes of 9 bits.
// Inputs change 1 time unit after each rising edge and outputs are sampled
// at that same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_layer_collector;

    localparam int N = 9;
    localparam int W = 9;

    logic           clk;
    logic           rst;
    logic [N-1:0]   end_in;
    logic [N*W-1:0] out_in;
    logic           next_ready;
    logic [N*W-1:0] layer_out;
    logic           start_out;
    logic           busy;
    logic           dup_err;
    logic           ovr_err;
    logic [15:0]    fire_cnt;

    int checks;
    int errors;

    layer_collector #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .end_in     (end_in),
        .out_in     (out_in),
        .next_ready (next_ready),
        .layer_out  (layer_out),
        .start_out  (start_out),
        .busy       (busy),
        .dup_err    (dup_err),
        .ovr_err    (ovr_err),
        .fire_cnt   (fire_cnt)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Place one W-bit value into lane idx of a packed vector.
    function automatic logic [N*W-1:0] put_lane(input logic [N*W-1:0] vec,
                                                input int idx,
                                                input logic [W-1:0] val);
        logic [N*W-1:0] r;
        r = vec;
        r[idx*W +: W] = val;
        return r;
    endfunction

    task automatic test_reset();
        rst        = 1'b1;
        end_in     = '0;
        out_in     = '0;
        next_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({layer_out, start_out, busy, dup_err, ovr_err, fire_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got lo=%h st=%b busy=%b dup=%b ovr=%b cnt=%h required all zero",
                     layer_out, start_out, busy, dup_err, ovr_err, fire_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || start_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy=%b st=%b required 0 0", busy, start_out);
        end
    endtask

    task automatic test_simultaneous();
        logic [N*W-1:0] vec;
        vec = '0;
        for (int i = 0; i < N; i++) vec = put_lane(vec, i, W'(i + 1));
        next_ready = 1'b1;
        end_in     = '1;
        out_in     = vec;
        tick();
        end_in = '0;
        out_in = '0;
        checks++;
        if (start_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_hold: got st=%b busy=%b required 0 1", start_out, busy);
        end
        tick();
        checks++;
        if (start_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_start: got %b required 1", start_out);
        end
        checks++;
        if (layer_out !== vec) begin
            errors++;
            $display("[TB] FAIL simul_data: got %h required %h", layer_out, vec);
        end
        checks++;
        if (fire_cnt !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_cnt_busy: got cnt=%0d busy=%b required 1 0", fire_cnt, busy);
        end
        tick();
        checks++;
        if (start_out !== 1'b0 || layer_out !== vec) begin
            errors++;
            $display("[TB] FAIL simul_pulse_end: got st=%b lo=%h required 0 %h", start_out, layer_out, vec);
        end
    endtask

    task automatic test_staggered();
        int             order [N] = '{8, 3, 0, 1, 2, 4, 5, 6, 7};
        logic [N*W-1:0] vec;
        logic [N*W-1:0] junk;
        vec  = '0;
        junk = '1;
        for (int i = 0; i < N; i++) vec = put_lane(vec, i, W'(9'h100 | i));
        next_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            end_in           = '0;
            end_in[order[k]] = 1'b1;
            out_in           = put_lane(junk, order[k], W'(9'h100 | order[k]));
            tick();
            end_in = '0;
            out_in = junk;
            checks++;
            if (busy !== 1'b1 || start_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stag_arrive%0d: got busy=%b st=%b required 1 0", k, busy, start_out);
            end
            if (k < N - 1) begin
                tick();
                checks++;
                if (busy !== 1'b1 || start_out !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stag_gap%0d: got busy=%b st=%b required 1 0", k, busy, start_out);
                end
            end
        end
        tick();
        checks++;
        if (start_out !== 1'b1 || layer_out !== vec) begin
            errors++;
            $display("[TB] FAIL stag_fire: got st=%b lo=%h required 1 %h", start_out, layer_out, vec);
        end
        checks++;
        if (fire_cnt !== 16'd2 || dup_err !== 1'b0 || ovr_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stag_status: got cnt=%0d dup=%b ovr=%b required 2 0 0", fire_cnt, dup_err, ovr_err);
        end
        tick();
    endtask

    task automatic test_dup_backpressure();
        logic [N*W-1:0] vec;
        vec = '0;
        for (int i = 0; i < N; i++) vec = put_lane(vec, i, W'(9'h040 | i));
        vec        = put_lane(vec, 4, 9'h0AA);
        next_ready = 1'b0;
        end_in     = 9'h010;
        out_in     = put_lane('0, 4, 9'h0AA);
        tick();
        checks++;
        if (dup_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dup_first: got %b required 0", dup_err);
        end
        out_in = put_lane('0, 4, 9'h155);
        tick();
        end_in = '0;
        checks++;
        if (dup_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL dup_second: got %b required 1", dup_err);
        end
        end_in = 9'h1EF;
        out_in = put_lane(vec, 4, 9'h155);
        tick();
        end_in = '0;
        out_in = '0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (start_out !== 1'b0 || busy !== 1'b1 || ovr_err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_wait%0d: got st=%b busy=%b ovr=%b required 0 1 0", c, start_out, busy, ovr_err);
            end
            tick();
        end
        next_ready = 1'b1;
        tick();
        checks++;
        if (start_out !== 1'b1 || layer_out !== vec) begin
            errors++;
            $display("[TB] FAIL bp_fire: got st=%b lo=%h required 1 %h", start_out, layer_out, vec);
        end
        checks++;
        if (fire_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL bp_cnt: got %0d required 3", fire_cnt);
        end
        tick();
        checks++;
        if (start_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_single: got %b required 0", start_out);
        end
    endtask

    task automatic test_overrun();
        logic [N*W-1:0] vec;
        vec = '0;
        for (int i = 0; i < N; i++) vec = put_lane(vec, i, W'(9'h0C0 | i));
        next_ready = 1'b0;
        end_in     = '1;
        out_in     = vec;
        tick();
        end_in = 9'h004;
        out_in = put_lane(vec, 2, 9'h1EE);
        tick();
        end_in = '0;
        out_in = '0;
        checks++;
        if (ovr_err !== 1'b1 || start_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovr_flag: got ovr=%b st=%b required 1 0", ovr_err, start_out);
        end
        next_ready = 1'b1;
        tick();
        checks++;
        if (start_out !== 1'b1 || layer_out !== vec) begin
            errors++;
            $display("[TB] FAIL ovr_data: got st=%b lo=%h required 1 %h", start_out, layer_out, vec);
        end
        checks++;
        if (fire_cnt !== 16'd4 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovr_after: got cnt=%0d busy=%b required 4 0", fire_cnt, busy);
        end
        tick();
    endtask

    task automatic test_fire_edge();
        logic [N*W-1:0] vec_b;
        logic [N*W-1:0] vec_c;
        vec_b = '0;
        vec_c = '0;
        for (int i = 0; i < N; i++) begin
            vec_b = put_lane(vec_b, i, W'(9'h020 + i));
            vec_c = put_lane(vec_c, i, W'(9'h1F0 - i));
        end
        next_ready = 1'b0;
        end_in     = '1;
        out_in     = vec_b;
        tick();
        next_ready = 1'b1;
        out_in     = vec_c;
        tick();
        end_in     = '0;
        out_in     = '0;
        next_ready = 1'b0;
        checks++;
        if (start_out !== 1'b1 || layer_out !== vec_b) begin
            errors++;
            $display("[TB] FAIL fedge_first: got st=%b lo=%h required 1 %h", start_out, layer_out, vec_b);
        end
        checks++;
        if (busy !== 1'b1 || fire_cnt !== 16'd5) begin
            errors++;
            $display("[TB] FAIL fedge_hold: got busy=%b cnt=%0d required 1 5", busy, fire_cnt);
        end
        tick();
        next_ready = 1'b1;
        checks++;
        if (start_out !== 1'b0 || layer_out !== vec_b) begin
            errors++;
            $display("[TB] FAIL fedge_gap: got st=%b lo=%h required 0 %h", start_out, layer_out, vec_b);
        end
        tick();
        checks++;
        if (start_out !== 1'b1 || layer_out !== vec_c || fire_cnt !== 16'd6) begin
            errors++;
            $display("[TB] FAIL fedge_second: got st=%b lo=%h cnt=%0d required 1 %h 6",
                     start_out, layer_out, fire_cnt, vec_c);
        end
        tick();
    endtask

    task automatic test_reset_wrap();
        logic [N*W-1:0] vec;
        vec = '0;
        for (int i = 0; i < N; i++) vec = put_lane(vec, i, W'(9'h011 * (i + 1)));
        next_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            end_in    = '0;
            end_in[i] = 1'b1;
            out_in    = vec;
            tick();
        end
        end_in = '0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({layer_out, start_out, busy, dup_err, ovr_err, fire_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got lo=%h st=%b busy=%b dup=%b ovr=%b cnt=%h required all zero",
                     layer_out, start_out, busy, dup_err, ovr_err, fire_cnt);
        end
        rst = 1'b0;
        tick();
        end_in = 9'h1E0;
        out_in = vec;
        tick();
        end_in = '0;
        tick();
        tick();
        checks++;
        if (start_out !== 1'b0 || fire_cnt !== 16'd0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lost_lanes: got st=%b cnt=%0d busy=%b required 0 0 1", start_out, fire_cnt, busy);
        end
        end_in = 9'h01F;
        tick();
        end_in = '1;
        for (int k = 0; k < 65535; k++) tick();
        checks++;
        if (fire_cnt !== 16'hFFFF || start_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cnt_max: got cnt=%h st=%b required ffff 1", fire_cnt, start_out);
        end
        tick();
        end_in = '0;
        checks++;
        if (fire_cnt !== 16'h0000 || start_out !== 1'b1 || layer_out !== vec) begin
            errors++;
            $display("[TB] FAIL cnt_wrap: got cnt=%h st=%b lo=%h required 0000 1 %h",
                     fire_cnt, start_out, layer_out, vec);
        end
        tick();
        tick();
        checks++;
        if (fire_cnt !== 16'h0001 || start_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cnt_after_wrap: got cnt=%h st=%b busy=%b required 0001 0 0",
                     fire_cnt, start_out, busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_simultaneous();
        test_staggered();
        test_dup_backpressure();
        test_overrun();
        test_fire_edge();
        test_reset_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
